// File: rtl/io_map_pkg.sv
// Shared I/O window definitions: register offsets and debounce FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: OFF_* word offsets (also decoded by the hub), db_state_t, status_word().
package io_map_pkg;

    localparam logic [1:0] OFF_SW_LEVEL  = 2'd0;
    localparam logic [1:0] OFF_KEY_LEVEL = 2'd1;
    localparam logic [1:0] OFF_KEY_EVT   = 2'd2;
    localparam logic [1:0] OFF_STATUS    = 2'd3;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_CHANGING = 1'b1
    } db_state_t;

    // STATUS register: {16'h0, NSW[7:0], NKEY[7:0]}
    function automatic logic [31:0] status_word(input int nsw, input int nkey);
        return {16'h0000, 8'(nsw), 8'(nkey)};
    endfunction

endpackage

// File: rtl/io_key_sw_input_if.sv
// Hub read port of the key/switch block: read strobe + word offset in, data + valid out.
// Latency: rdata/rvalid arrive one cycle after rd.
// Backpressure: none; one read accepted every cycle.
// Signals: rd (strobe), rd_off (word offset), rdata (32-bit data), rvalid (1-cycle pulse).
interface io_key_sw_input_if;
    logic        rd;
    logic [1:0]  rd_off;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output rd, output rd_off, input rdata, input rvalid);
    modport slave  (input rd, input rd_off, output rdata, output rvalid);
endinterface

// File: rtl/io_key_sw_input_debounce_bit.sv
// Single-bit 2-flop synchroniser + debounce FSM with registered rising-edge pulse.
// Latency: a held change reaches level DEBOUNCE_CYCLES edges after it leaves the synchroniser.
// Backpressure: none.
// Ports: clock, reset (sync, active-high), din_async (raw pad), level (debounced, 1 = active), rise (1-cycle 0->1 pulse).
module debounce_bit
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din_async,
    output logic level,
    output logic rise
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          w_sync;
    db_state_t     r_state;
    db_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          r_rise;
    logic          w_rise_nxt;

    // Synchroniser resets to the pad's idle level so nothing looks like a change after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= din_async;
            r_sync2 <= r_sync1;
        end
    end

    // Polarity is normalised after the synchroniser: internal 1 = active.
    assign w_sync = r_sync2 ^ ACTIVE_LOW;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        unique case (r_state)
            DB_STABLE: begin
                if (w_sync != r_level) begin
                    w_state_nxt = DB_CHANGING;
                    w_cnt_nxt   = CW'(1);
                end
            end
            DB_CHANGING: begin
                if (w_sync == r_level) begin
                    // glitch: input returned before the hold time elapsed
                    w_state_nxt = DB_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_level_nxt = w_sync;
                    w_rise_nxt  = w_sync;
                    w_state_nxt = DB_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = DB_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/io_key_sw_input.sv
// Debounced KEY/SW input peripheral on the hub I/O window, with sticky clear-on-read key-press events.
// Latency: read data/valid one cycle after rd; pad change visible DEBOUNCE_CYCLES+2 edges later.
// Backpressure: none; back-to-back reads are accepted every cycle.
// Ports: clock, reset (sync, active-high), key_n[NKEY] (active-low pads), sw[NSW], bus (slave read port), key_irq.
module io_key_sw_input
    import io_map_pkg::*;
#(
    parameter int NKEY            = 4,
    parameter int NSW             = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NKEY-1:0]     key_n,
    input  logic [NSW-1:0]      sw,
    io_key_sw_input_if.slave    bus,
    output logic                key_irq
);
    logic [NKEY-1:0] w_key_level;
    logic [NKEY-1:0] w_key_rise;
    logic [NSW-1:0]  w_sw_level;
    logic [NSW-1:0]  w_sw_rise_unused;
    logic [NKEY-1:0] r_evt;
    logic [NKEY-1:0] w_evt_nxt;
    logic            w_evt_clr;
    logic [31:0]     w_rd_sel;
    logic [31:0]     r_rdata;
    logic            r_rvalid;
    logic            r_key_irq;

    for (genvar g = 0; g < NKEY; g++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (1'b1)
        ) u_db (
            .clock     (clock),
            .reset     (reset),
            .din_async (key_n[g]),
            .level     (w_key_level[g]),
            .rise      (w_key_rise[g])
        );
    end

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (1'b0)
        ) u_db (
            .clock     (clock),
            .reset     (reset),
            .din_async (sw[g]),
            .level     (w_sw_level[g]),
            .rise      (w_sw_rise_unused[g])
        );
    end

    always_comb begin
        w_rd_sel = '0;
        unique case (bus.rd_off)
            OFF_SW_LEVEL:  w_rd_sel = 32'(w_sw_level);
            OFF_KEY_LEVEL: w_rd_sel = 32'(w_key_level);
            OFF_KEY_EVT:   w_rd_sel = 32'(r_evt);
            OFF_STATUS:    w_rd_sel = status_word(NSW, NKEY);
            default:       w_rd_sel = '0;
        endcase
    end

    // A clearing read reloads evt with this cycle's rises, so a press that
    // coincides with the read survives for the next access.
    assign w_evt_clr = bus.rd && (bus.rd_off == OFF_KEY_EVT);
    assign w_evt_nxt = w_evt_clr ? w_key_rise : (r_evt | w_key_rise);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_evt     <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_key_irq <= 1'b0;
        end else begin
            r_evt     <= w_evt_nxt;
            r_key_irq <= |w_evt_nxt;
            r_rvalid  <= bus.rd;
            if (bus.rd) begin
                r_rdata <= w_rd_sel;
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign key_irq    = r_key_irq;

endmodule

// File: tb/tb_io_key_sw_input.sv
module tb_io_key_sw_input;
    localparam int NKEY = 4;
    localparam int NSW  = 10;
    localparam int DB   = 4;
    localparam int NB   = NKEY + NSW;

    logic            clock = 1'b0;
    logic            reset;
    logic [NKEY-1:0] key_n;
    logic [NSW-1:0]  sw;
    logic            key_irq;

    io_key_sw_input_if bus();

    io_key_sw_input #(
        .NKEY            (NKEY),
        .NSW             (NSW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .key_n   (key_n),
        .sw      (sw),
        .bus     (bus),
        .key_irq (key_irq)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Internal view: bit b<NSW is sw[b], bit NSW+k is key k with 1 = pressed.
    // A level flips once the last DB synchronised samples all disagree with it.
    logic [NB-1:0]   m_p0, m_p1, m_lvl;
    logic [DB-1:0]   m_hist [NB];
    logic [NKEY-1:0] m_rise, m_evt;
    logic [31:0]     m_rdata;
    logic            m_rvalid, m_irq;
    logic            m_ok = 1'b0;

    task automatic model_step();
        logic [NB-1:0]   pad;
        logic [NB-1:0]   old;
        logic [NKEY-1:0] evt_n;
        logic [31:0]     sel;
        pad = {~key_n, sw};
        if (reset) begin
            m_p0 = '0; m_p1 = '0; m_lvl = '0;
            for (int b = 0; b < NB; b++) m_hist[b] = '0;
            m_rise = '0; m_evt = '0; m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
            m_ok = 1'b1;
        end else begin
            case (bus.rd_off)
                2'd0:    sel = 32'(m_lvl[NSW-1:0]);
                2'd1:    sel = 32'(m_lvl[NB-1:NSW]);
                2'd2:    sel = 32'(m_evt);
                default: sel = NSW * 256 + NKEY;
            endcase
            if (bus.rd) m_rdata = sel;
            m_rvalid = bus.rd;
            evt_n = (bus.rd && bus.rd_off == 2'd2) ? m_rise : (m_evt | m_rise);
            m_evt = evt_n;
            m_irq = |evt_n;
            old = m_lvl;
            for (int b = 0; b < NB; b++) begin
                m_hist[b] = {m_hist[b][DB-2:0], m_p1[b]};
                if (m_hist[b] == {DB{~m_lvl[b]}}) m_lvl[b] = ~m_lvl[b];
            end
            m_rise = m_lvl[NB-1:NSW] & ~old[NB-1:NSW];
            m_p1 = m_p0;
            m_p0 = pad;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Every-cycle compare, away from the active edge.
    initial forever begin
        @(negedge clock);
        if (m_ok) begin
            check("rdata",   bus.rdata,           m_rdata);
            check("rvalid",  {31'b0, bus.rvalid}, {31'b0, m_rvalid});
            check("key_irq", {31'b0, key_irq},    {31'b0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_read(input logic [1:0] off, output logic [31:0] d);
        bus.rd     = 1'b1;
        bus.rd_off = off;
        @(negedge clock);
        d      = bus.rdata;
        bus.rd = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1; key_n = '1; sw = '0; bus.rd = 1'b0; bus.rd_off = 2'd0;
        repeat (2) @(negedge clock);
        check("rst_rdata",  bus.rdata,           32'h0);
        check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
        check("rst_irq",    {31'b0, key_irq},    32'h0);
        reset = 1'b0;
        for (int o = 0; o < 4; o++) begin
            do_read(o[1:0], d);
            check("rst_read", d, (o == 3) ? 32'h00000A04 : 32'h0);
        end
        repeat (4) @(negedge clock);

        // debounce accept: sw[3] held, continuous SW_LEVEL reads
        sw[3] = 1'b1; bus.rd = 1'b1; bus.rd_off = 2'd0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clock);
            if (n == 6) check("db_early",  bus.rdata, 32'h0);
            if (n == 7) check("db_accept", bus.rdata, 32'h8);
        end
        bus.rd = 1'b0;

        // glitch reject on key 1
        key_n[1] = 1'b0;
        repeat (3) @(negedge clock);
        key_n[1] = 1'b1;
        repeat (8) @(negedge clock);
        check("glitch_irq", {31'b0, key_irq}, 32'h0);
        do_read(2'd1, d); check("glitch_lvl", d, 32'h0);
        do_read(2'd2, d); check("glitch_evt", d, 32'h0);

        // press event on key 0
        key_n[0] = 1'b0;
        repeat (10) @(negedge clock);
        check("press_irq", {31'b0, key_irq}, 32'h1);
        do_read(2'd2, d);
        check("evt_read1", d, 32'h1);
        check("irq_drop",  {31'b0, key_irq}, 32'h0);
        do_read(2'd2, d);
        check("evt_read2", d, 32'h0);
        key_n[0] = 1'b1;
        repeat (10) @(negedge clock);

        // re-press key 0 to leave evt=1, then read on the cycle key 2 rises
        key_n[0] = 1'b0;
        repeat (10) @(negedge clock);
        key_n[2] = 1'b0;
        repeat (6) @(negedge clock);
        do_read(2'd2, d); check("simul_old", d, 32'h1);
        do_read(2'd2, d); check("simul_new", d, 32'h4);
        key_n[2] = 1'b1; key_n[0] = 1'b1;
        repeat (10) @(negedge clock);

        // reset mid-debounce on sw[0], then back-to-back reads
        sw[0] = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; bus.rd = 1'b1; bus.rd_off = 2'd0;
        for (int n = 6; n <= 12; n++) begin
            @(negedge clock);
            if (n == 6 || n == 7) check("b2b_rvalid", {31'b0, bus.rvalid}, 32'h1);
            if (n == 6)  check("rstmid_lvl0",  bus.rdata, 32'h0);
            if (n == 11) check("rstmid_early", bus.rdata, 32'h0);
            if (n == 12) check("rstmid_lvl",   bus.rdata, 32'h9);
        end
        bus.rd = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 11) == 0) begin
                int b;
                b = $urandom_range(0, NB - 1);
                if (b < NSW) sw[b] = ~sw[b];
                else         key_n[b - NSW] = ~key_n[b - NSW];
            end
            bus.rd     = ($urandom_range(0, 1) == 1);
            bus.rd_off = 2'($urandom_range(0, 3));
        end
        reset = 1'b0; bus.rd = 1'b0;
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
